norm_lshift: RTL

NORM_LSHIFT -- requirements
Module: norm_lshift

---
 rtl/fp_add_pkg.sv | 11 +
 rtl/lzc.sv | 22 ++
 rtl/norm_lshift.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared widths and types for the FP adder datapath: default mantissa/exponent
// widths and the shift-amount type sized to hold 0..MANT_W.
package fp_add_pkg;

    localparam int DEF_MANT_W = 28;
    localparam int DEF_EXP_W  = 8;
    localparam int SHAMT_W    = $clog2(DEF_MANT_W + 1);

    typedef logic [SHAMT_W-1:0] lzc_t;

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; an all-zero input returns MANT_W.
module lzc
    import fp_add_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int CNT_W  = SHAMT_W
) (
    input  logic [MANT_W-1:0] mant,
    output logic [CNT_W-1:0]  count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CNT_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant[i]) begin
                count = CNT_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_lshift.sv
// Two-stage left normalizer with valid/ready handshake on both sides.
// NORM_LSHIFT_DENORM_EN: underflow yields a denormal instead of flushing to zero.
module norm_lshift
    import fp_add_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_uflow
);

    localparam int CMP_W = (EXP_W > SHAMT_W) ? EXP_W : SHAMT_W;

    function automatic logic is_uflow(input lzc_t lz, input logic [EXP_W-1:0] e);
        return CMP_W'(lz) >= CMP_W'(e);
    endfunction

`ifdef NORM_LSHIFT_DENORM_EN
    // On underflow e <= lzc <= MANT_W, so e-1 always fits the shift type.
    function automatic lzc_t denorm_shamt(input logic [EXP_W-1:0] e);
        return (e != '0) ? lzc_t'(e - EXP_W'(1)) : '0;
    endfunction
`endif

    logic              vld_p1, vld_p2;
    logic              sign_p1, sign_p2;
    logic [EXP_W-1:0]  exp_p1, exp_p2;
    logic [MANT_W-1:0] mant_p1, mant_p2;
    lzc_t              lzc_p1;
    logic              zero_p2, uflow_p2;

    lzc_t              lzc_in;
    logic              adv2, take_in;

    lzc_t              shamt;
    logic [EXP_W-1:0]  exp_nxt;
    logic              zero_nxt, uflow_nxt, keep_mant;
    logic [MANT_W-1:0] lvl [SHAMT_W+1];

    lzc #(
        .MANT_W (MANT_W),
        .CNT_W  (SHAMT_W)
    ) u_lzc (
        .mant  (in_mant),
        .count (lzc_in)
    );

    assign adv2     = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv2;
    assign take_in  = in_valid && in_ready;

    // ---- stage 1: capture input and its leading-zero count ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            sign_p1 <= 1'b0;
            exp_p1  <= '0;
            mant_p1 <= '0;
            lzc_p1  <= '0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (take_in) begin
                sign_p1 <= in_sign;
                exp_p1  <= in_exp;
                mant_p1 <= in_mant;
                lzc_p1  <= lzc_in;
            end
        end
    end

    always_comb begin
        shamt     = lzc_p1;
        exp_nxt   = exp_p1 - EXP_W'(lzc_p1);
        zero_nxt  = (mant_p1 == '0);
        uflow_nxt = 1'b0;
        keep_mant = 1'b1;
        if (zero_nxt) begin
            exp_nxt = '0;
        end else if (is_uflow(lzc_p1, exp_p1)) begin
            uflow_nxt = 1'b1;
            exp_nxt   = '0;
`ifdef NORM_LSHIFT_DENORM_EN
            shamt     = denorm_shamt(exp_p1);
`else
            keep_mant = 1'b0;
`endif
        end
    end

    // Barrel shifter: level k shifts by 2**k when shamt[k] is set.
    assign lvl[0] = mant_p1;
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_shift
        assign lvl[k+1] = shamt[k] ? (lvl[k] << (2**k)) : lvl[k];
    end

    // ---- stage 2: shifted mantissa, adjusted exponent, flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            sign_p2  <= 1'b0;
            exp_p2   <= '0;
            mant_p2  <= '0;
            zero_p2  <= 1'b0;
            uflow_p2 <= 1'b0;
        end else begin
            if (adv2) begin
                vld_p2 <= vld_p1;
            end
            if (adv2 && vld_p1) begin
                sign_p2  <= sign_p1;
                exp_p2   <= exp_nxt;
                mant_p2  <= keep_mant ? lvl[SHAMT_W] : '0;
                zero_p2  <= zero_nxt;
                uflow_p2 <= uflow_nxt;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_sign  = sign_p2;
    assign out_exp   = exp_p2;
    assign out_mant  = mant_p2;
    assign out_zero  = zero_p2;
    assign out_uflow = uflow_p2;

endmodule
